spi_master: RTL and testbench

- SPI mode-0 master (CPOL=0, CPHA=0), MSB first, one fixed-length frame per request.
- Drives a serial slave (on-board ADC, or an FPGA-side SPI slave on a bench loopback) from the 50 MHz system clock.
- User side is a start/busy/done handshake with parallel tx/rx words.
- SCLK is generated internally from a parameterised divider; CS is framed with setup and hold margins.

---
 rtl/spi_master.sv | 155 +++++++++++++++
 tb/tb_spi_master.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master
//  Purpose  : SPI mode-0 master, MSB first, one DATA_W-bit frame per start.
//  Revision : 1.0
// ============================================================================
module spi_master #(
    parameter int DATA_W   = 32,
    parameter int CLK_DIV  = 25,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] tx_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              sclk_o,
    output logic              cs_n_o,
    output logic              mosi_o,
    input  logic              miso_i
);

    localparam int c_CS_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int c_CNT_W  = (c_CS_MAX > 1) ? $clog2(c_CS_MAX) : 1;
    localparam int c_DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_BIT_W  = $clog2(DATA_W + 1);

    localparam logic [c_CNT_W-1:0] c_SETUP_LAST = c_CNT_W'(CS_SETUP - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(CS_HOLD - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST   = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE    = c_DIV_W'(1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST   = c_BIT_W'(DATA_W);
    localparam logic [c_BIT_W-1:0] c_BIT_ONE    = c_BIT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_XFER  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t              state_q;
    logic [c_CNT_W-1:0]  cnt_q;
    logic [c_DIV_W-1:0]  div_q;
    logic [c_BIT_W-1:0]  bit_q;
    logic [DATA_W-1:0]   tx_q;
    logic [DATA_W-1:0]   rx_q;
    logic                busy_q;
    logic                done_q;
    logic [DATA_W-1:0]   rx_data_q;
    logic                sclk_q;
    logic                cs_n_q;
    logic                mosi_q;

    logic [DATA_W-1:0]   tx_d;
    logic [DATA_W-1:0]   rx_d;
    logic [c_BIT_W-1:0]  bit_d;

    // Shift helpers written without part-selects so DATA_W=1 stays legal.
    always_comb begin
        tx_d    = tx_q << 1;
        rx_d    = rx_q << 1;
        rx_d[0] = miso_i;
        bit_d   = bit_q + c_BIT_ONE;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        tx_q    <= tx_data_i;
                        mosi_q  <= tx_data_i[DATA_W-1];
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt_q == c_SETUP_LAST) begin
                        cnt_q   <= '0;
                        div_q   <= '0;
                        bit_q   <= '0;
                        state_q <= S_XFER;
                    end else begin
                        cnt_q <= cnt_q + c_CNT_ONE;
                    end
                end
                S_XFER: begin
                    if (div_q == c_DIV_LAST) begin
                        div_q  <= '0;
                        sclk_q <= ~sclk_q;
                        if (!sclk_q) begin
                            rx_q <= rx_d;
                        end else begin
                            // Falling edge: advance to the next bit, or stop with mosi untouched.
                            bit_q <= bit_d;
                            if (bit_d == c_BIT_LAST) begin
                                cnt_q   <= '0;
                                state_q <= S_HOLD;
                            end else begin
                                tx_q   <= tx_d;
                                mosi_q <= tx_d[DATA_W-1];
                            end
                        end
                    end else begin
                        div_q <= div_q + c_DIV_ONE;
                    end
                end
                S_HOLD: begin
                    if (cnt_q == c_HOLD_LAST) begin
                        cnt_q     <= '0;
                        cs_n_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        rx_data_q <= rx_q;
                        mosi_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + c_CNT_ONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rx_data_o = rx_data_q;
    assign sclk_o    = sclk_q;
    assign cs_n_o    = cs_n_q;
    assign mosi_o    = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_master
//  Purpose  : Self-checking bench for spi_master (fast-divider and default copies).
//  Revision : 1.0
// ============================================================================
module tb_spi_master;

    localparam int W      = 32;
    localparam int A_DIV  = 2;
    localparam int A_BUSY = 2 + 2 * W * A_DIV + 2;
    localparam int B_BUSY = 1604;

    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Instance A: CLK_DIV=2, miso selected by a_mode (0 loopback, 1 const high, 2 const low)
    logic         a_start;
    logic [W-1:0] a_tx;
    logic [1:0]   a_mode;
    logic         a_miso;
    logic         a_busy, a_done, a_sclk, a_csn, a_mosi;
    logic [W-1:0] a_rx;
    assign a_miso = (a_mode == 2'd0) ? a_mosi : (a_mode == 2'd1);

    spi_master #(.DATA_W(W), .CLK_DIV(A_DIV), .CS_SETUP(2), .CS_HOLD(2)) u_dut_a (
        .clk_i(clk), .reset_i(reset), .start_i(a_start), .tx_data_i(a_tx),
        .busy_o(a_busy), .done_o(a_done), .rx_data_o(a_rx), .sclk_o(a_sclk),
        .cs_n_o(a_csn), .mosi_o(a_mosi), .miso_i(a_miso)
    );

    // Instance B: default parameters, driven by a slave that shifts out a fixed word
    logic         b_start;
    logic [W-1:0] b_tx;
    logic         b_miso;
    logic         b_busy, b_done, b_sclk, b_csn, b_mosi;
    logic [W-1:0] b_rx;
    logic [W-1:0] slave_word = 32'h7FFF_FFFF + 32'd5;
    int           b_fall = 0;
    logic         b_sclk_p = 1'b0;
    assign b_miso = (b_fall < W) ? slave_word[W-1-b_fall] : 1'b0;

    always @(negedge clk) begin
        if (b_csn) b_fall = 0;
        else if (b_sclk_p && !b_sclk) b_fall++;
        b_sclk_p = b_sclk;
    end

    spi_master u_dut_b (
        .clk_i(clk), .reset_i(reset), .start_i(b_start), .tx_data_i(b_tx),
        .busy_o(b_busy), .done_o(b_done), .rx_data_o(b_rx), .sclk_o(b_sclk),
        .cs_n_o(b_csn), .mosi_o(b_mosi), .miso_i(b_miso)
    );

    // Scoreboard and per-frame monitor for instance A
    logic [W-1:0] exp_q[$];
    logic [W-1:0] a_acc_tx = '0;
    int   a_bcnt = 0, a_rises = 0, a_falls = 0, a_since = 0, a_gap_bad = 0, a_mosi_bad = 0;
    logic a_busy_p = 1'b0, a_sclk_p = 1'b0, a_exp_mosi;

    always @(posedge clk) begin
        if (!reset && !a_busy && a_start) a_acc_tx <= a_tx;
    end

    always @(negedge clk) begin
        if (reset) begin
            a_bcnt = 0; a_rises = 0; a_falls = 0; a_since = 0; a_gap_bad = 0; a_mosi_bad = 0;
        end else begin
            if (a_busy) a_bcnt++;
            if (a_sclk && !a_sclk_p) begin
                if (a_rises > 0 && a_since != 2 * A_DIV) a_gap_bad++;
                a_rises++;
                a_since = 0;
            end
            a_since++;
            if (a_csn) a_falls = 0;
            else if (!a_sclk && a_sclk_p) a_falls++;
            // mosi carries tx[W-1-falls] while selected, holds bit 0 through hold, 0 when idle
            a_exp_mosi = a_csn ? 1'b0 : a_acc_tx[(a_falls < W) ? W - 1 - a_falls : 0];
            if (a_mosi !== a_exp_mosi) a_mosi_bad++;
            if (!a_busy && a_busy_p) begin
                chk("busy_len", a_bcnt, A_BUSY);
                chk("sclk_rises", a_rises, W);
                chk("sclk_gap_errs", a_gap_bad, 0);
                chk("mosi_errs", a_mosi_bad, 0);
                a_bcnt = 0; a_rises = 0; a_gap_bad = 0; a_mosi_bad = 0;
            end
            if (a_done) begin
                if (exp_q.size() == 0) chk("unexpected_done", a_done, 0);
                else chk("rx_data", a_rx, exp_q.pop_front());
            end
        end
        a_busy_p = a_busy;
        a_sclk_p = a_sclk;
    end

    task automatic pulse_a(input logic [W-1:0] tx);
        @(negedge clk);
        a_tx    = tx;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic wait_q(input int budget);
        for (int k = 0; k < budget && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            chk("frame_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    typedef struct {
        logic [W-1:0] tx;
        logic [1:0]   mode;
        logic [W-1:0] exp_rx;
    } vec_t;
    vec_t tbl[3];

    int nr, csf, r1, lf, csr, bcnt;
    logic ps, dn;

    initial begin
        tbl[0] = '{32'hA5C3_0F81, 2'd0, 32'hA5C3_0F81};
        tbl[1] = '{32'h8000_0000, 2'd1, 32'hFFFF_FFFF};
        tbl[2] = '{32'h8000_0000, 2'd2, 32'h0000_0000};

        reset = 1'b1; a_start = 1'b1; b_start = 1'b1;
        a_tx = 32'hFFFF_FFFF; b_tx = '0; a_mode = 2'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_busy", a_busy, 0);
        end
        chk("reset_done", a_done, 0);
        chk("reset_cs_n", a_csn, 1);
        chk("reset_sclk", a_sclk, 0);
        chk("reset_mosi", a_mosi, 0);
        chk("reset_rx", a_rx, 0);
        chk("reset_busy_b", b_busy, 0);
        @(posedge clk); #1;
        reset = 1'b0; a_start = 1'b0; b_start = 1'b0;
        @(negedge clk);
        chk("idle_cs_n", a_csn, 1);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_mode = tbl[i].mode;
            exp_q.push_back(tbl[i].exp_rx);
            pulse_a(tbl[i].tx);
            wait_q(400);
            repeat (3) @(negedge clk);
        end

        // Mid-frame start is ignored; start held across done chains a second frame
        a_mode = 2'd0;
        exp_q.push_back(32'h1111_2222);
        pulse_a(32'h1111_2222);
        repeat (48) @(negedge clk);
        a_tx = 32'hDEAD_BEEF; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (20) @(negedge clk);
        a_start = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (a_done) break;
        end
        chk("b2b_done_seen", a_done, 1);
        a_tx = 32'h3333_4444;
        exp_q.push_back(32'h3333_4444);
        @(negedge clk);
        chk("b2b_cs_gap", a_csn, 0);
        chk("b2b_busy", a_busy, 1);
        a_start = 1'b0; a_tx = 32'hFFFF_0000;
        wait_q(400);
        repeat (3) @(negedge clk);

        // Reset after the 10th rising edge aborts the frame
        pulse_a(32'hCAFE_F00D);
        nr = 0; ps = 1'b0;
        for (int k = 0; k < 200 && nr < 10; k++) begin
            @(negedge clk);
            if (a_sclk && !ps) nr++;
            ps = a_sclk;
        end
        chk("rises_before_reset", nr, 10);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_cs_n", a_csn, 1);
        chk("abort_sclk", a_sclk, 0);
        chk("abort_busy", a_busy, 0);
        chk("abort_done", a_done, 0);
        chk("abort_rx", a_rx, 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (10) @(negedge clk);
        exp_q.push_back(32'h1234_5678);
        pulse_a(32'h1234_5678);
        wait_q(400);

        // Default divider with slave model
        @(negedge clk);
        b_tx = 32'h0F0F_0F0F; b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        csf = -1; r1 = -1; lf = -1; csr = -1; bcnt = 0; ps = 1'b0; dn = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (b_busy) bcnt++;
            if (!b_csn && csf < 0) csf = k;
            if (b_sclk && !ps && r1 < 0) r1 = k;
            if (!b_sclk && ps) lf = k;
            if (b_csn && csf >= 0 && csr < 0) csr = k;
            if (b_done) begin
                chk("b_rx", b_rx, 32'h8000_0004);
                dn = 1'b1;
            end
            ps = b_sclk;
            if (dn) break;
            @(negedge clk);
        end
        chk("b_done_seen", dn, 1);
        chk("b_busy_len", bcnt, B_BUSY);
        // The transfer opens with a low half-period, so the first rise trails cs_n by CS_SETUP+CLK_DIV.
        chk("b_cs_to_first_rise", r1 - csf, 27);
        chk("b_last_fall_to_cs_rise", csr - lf, 2);
        @(negedge clk);
        chk("b_done_once", b_done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
